// File: rtl/des_cbc_dec_ctrl.sv
// des_cbc_dec_ctrl: CBC-mode decryption sequencer around an external
// single-block DES core (decrypt direction). One block in flight at a time:
// take ciphertext, launch the core, XOR its result with the chaining value,
// hand back plaintext, then adopt the ciphertext as the next chaining value.
//
// Optional build macro DES_CBC_DEC_TIMEOUT_EN adds a WAIT-state watchdog
// and the sticky err output.
module des_cbc_dec_ctrl #(
    parameter int CORE_LAT = 17,
    parameter int TIMEOUT  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key,
    input  logic        iv_load,
    input  logic [63:0] iv,
    input  logic [63:0] ct,
    input  logic        ct_vld,
    output logic        ct_rdy,
    output logic [63:0] pt,
    output logic        pt_vld,
    input  logic        pt_rdy,
    output logic [63:0] core_data,
    output logic        core_data_vld,
    output logic [63:0] core_key,
    input  logic [63:0] core_result,
    input  logic        core_result_vld,
    output logic        busy,
    output logic [15:0] blk_cnt
`ifdef DES_CBC_DEC_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    // The watchdog limit must leave room for a nominal core response.
    if (TIMEOUT <= CORE_LAT) begin : g_bad_cfg
        $error("des_cbc_dec_ctrl: TIMEOUT must exceed CORE_LAT");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pt_q, pt_d;
    logic        pt_vld_q, pt_vld_d;
    logic [63:0] core_data_q, core_data_d;
    logic        core_data_vld_q, core_data_vld_d;
    logic [63:0] core_key_q, core_key_d;
    logic [63:0] chain_q, chain_d;
    logic [63:0] ct_reg_q, ct_reg_d;
    logic [15:0] blk_cnt_q, blk_cnt_d;

`ifdef DES_CBC_DEC_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
`endif

    // A new block may only be taken in IDLE, and an IV load has priority.
    assign ct_rdy        = (state_q == S_IDLE) && !iv_load;
    assign pt            = pt_q;
    assign pt_vld        = pt_vld_q;
    assign core_data     = core_data_q;
    assign core_data_vld = core_data_vld_q;
    assign core_key      = core_key_q;
    assign busy          = (state_q != S_IDLE);
    assign blk_cnt       = blk_cnt_q;
`ifdef DES_CBC_DEC_TIMEOUT_EN
    assign err           = err_q;
`endif

    // Next-state and datapath update for the four-phase block sequence.
    always_comb begin
        state_d         = state_q;
        pt_d            = pt_q;
        pt_vld_d        = pt_vld_q;
        core_data_d     = core_data_q;
        core_data_vld_d = 1'b0;
        core_key_d      = core_key_q;
        chain_d         = chain_q;
        ct_reg_d        = ct_reg_q;
        blk_cnt_d       = blk_cnt_q;
`ifdef DES_CBC_DEC_TIMEOUT_EN
        wait_cnt_d      = wait_cnt_q;
        err_d           = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (iv_load) begin
                    chain_d   = iv;
                    blk_cnt_d = 16'd0;
`ifdef DES_CBC_DEC_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end else if (ct_vld) begin
                    core_data_d     = ct;
                    core_key_d      = key;
                    ct_reg_d        = ct;
                    core_data_vld_d = 1'b1;
                    state_d         = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // core_data_vld is high for this single cycle only.
                state_d = S_WAIT;
`ifdef DES_CBC_DEC_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (core_result_vld) begin
                    pt_d     = core_result ^ chain_q;
                    chain_d  = ct_reg_q;
                    pt_vld_d = 1'b1;
                    state_d  = S_OUT;
                end
`ifdef DES_CBC_DEC_TIMEOUT_EN
                else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
                    // Abandon the block: chain and count stay untouched.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            S_OUT: begin
                if (pt_rdy) begin
                    pt_vld_d  = 1'b0;
                    blk_cnt_d = blk_cnt_q + 16'd1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; asynchronous reset returns to a clean IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            pt_q            <= 64'd0;
            pt_vld_q        <= 1'b0;
            core_data_q     <= 64'd0;
            core_data_vld_q <= 1'b0;
            core_key_q      <= 64'd0;
            chain_q         <= 64'd0;
            blk_cnt_q       <= 16'd0;
`ifdef DES_CBC_DEC_TIMEOUT_EN
            wait_cnt_q      <= '0;
            err_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            pt_q            <= pt_d;
            pt_vld_q        <= pt_vld_d;
            core_data_q     <= core_data_d;
            core_data_vld_q <= core_data_vld_d;
            core_key_q      <= core_key_d;
            chain_q         <= chain_d;
            blk_cnt_q       <= blk_cnt_d;
`ifdef DES_CBC_DEC_TIMEOUT_EN
            wait_cnt_q      <= wait_cnt_d;
            err_q           <= err_d;
`endif
        end
    end

    // Ciphertext copy for the next chaining value; only read after being written.
    always_ff @(posedge clk) begin
        ct_reg_q <= ct_reg_d;
    end

endmodule

// File: tb/tb_des_cbc_dec_ctrl.sv
// Bench for des_cbc_dec_ctrl: stand-in DES core, scoreboard of expected
// plaintext built from CBC rules (pt = D(ct) ^ previous ct / iv), and a
// monitor that checks every delivered plaintext block.
module tb_des_cbc_dec_ctrl;

    localparam int CORE_LAT = 17;
    localparam int TIMEOUT  = 32;

    localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key;
    logic        iv_load;
    logic [63:0] iv;
    logic [63:0] ct;
    logic        ct_vld;
    logic        ct_rdy;
    logic [63:0] pt;
    logic        pt_vld;
    logic        pt_rdy = 1'b0;
    logic [63:0] core_data;
    logic        core_data_vld;
    logic [63:0] core_key;
    logic [63:0] core_result = 64'd0;
    logic        core_result_vld = 1'b0;
    logic        busy;
    logic [15:0] blk_cnt;
`ifdef DES_CBC_DEC_TIMEOUT_EN
    logic        err;
`endif

    des_cbc_dec_ctrl #(.CORE_LAT(CORE_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .key(key), .iv_load(iv_load), .iv(iv),
        .ct(ct), .ct_vld(ct_vld), .ct_rdy(ct_rdy),
        .pt(pt), .pt_vld(pt_vld), .pt_rdy(pt_rdy),
        .core_data(core_data), .core_data_vld(core_data_vld), .core_key(core_key),
        .core_result(core_result), .core_result_vld(core_result_vld),
        .busy(busy), .blk_cnt(blk_cnt)
`ifdef DES_CBC_DEC_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] pt;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    // Reference state: chaining value and delivered-block count.
    logic [63:0] m_chain = 64'd0;
    logic [15:0] m_cnt = 16'd0;

    // Stand-in for the DES decrypt core: known answer for the textbook
    // vector, an arbitrary deterministic mix otherwise.
    function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [63:0] k);
        if (d == KAT_CT && k == KAT_KEY) return KAT_PT;
        return d ^ {k[31:0], k[63:32]} ^ 64'h5A5A3C3C0F0F9696;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Core model: result_vld CORE_LAT cycles after seeing data_vld.
    int          core_cnt = 0;
    logic [63:0] core_pend = 64'd0;
    bit          core_silent = 1'b0;
    int          spur_req_n = 0;
    int          spur_done_n = 0;
    always @(negedge clk) begin
        core_result_vld = 1'b0;
        if (spur_req_n != spur_done_n) begin
            spur_done_n     = spur_req_n;
            core_result_vld = 1'b1;
            core_result     = {$urandom, $urandom};
        end
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_result_vld = 1'b1;
                core_result     = core_pend;
            end
        end
        if (core_data_vld && !core_silent) begin
            core_cnt  = CORE_LAT;
            core_pend = core_fn(core_data, core_key);
        end
    end

    // Downstream ready: fixed level or random backpressure.
    bit rdy_rand  = 1'b0;
    bit rdy_force = 1'b1;
    always @(posedge clk) begin
        #1;
        pt_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Monitor: every delivered plaintext must match the head of the scoreboard.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && pt_vld && pt_rdy) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: pt %h delivered, none expected", pt);
            end else begin
                mon_e = sb_q.pop_front();
                check64("pt", pt, mon_e.pt);
                check64("blk_cnt_at_out", {48'd0, blk_cnt}, {48'd0, mon_e.cnt});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_iv(input logic [63:0] v);
        iv_load = 1'b1;
        iv      = v;
        tick();
        iv_load = 1'b0;
        m_chain = v;
        m_cnt   = 16'd0;
    endtask

    // Offer one block; returns at the start of the cycle after acceptance.
    task automatic send(input logic [63:0] c, input logic [63:0] k, input bit expect_it);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        ct = c;
        key = k;
        ct_vld = 1'b1;
        while (n < 300) begin
            @(negedge clk);
            if (ct_rdy) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (ok) begin
            if (expect_it) begin
                sb_q.push_back('{pt: core_fn(c, k) ^ m_chain, cnt: m_cnt});
                m_chain = c;
                m_cnt   = m_cnt + 16'd1;
            end
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: ct_rdy 0, expected 1 within 300 cycles");
        end
        tick();
        ct_vld = 1'b0;
    endtask

    // Wait until all expected blocks are delivered and the sequencer is idle.
    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d blocks outstanding, expected 0", sb_q.size());
        end
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check64({tag, "_pt"}, pt, 64'd0);
        check64({tag, "_pt_vld"}, {63'd0, pt_vld}, 64'd0);
        check64({tag, "_core_data"}, core_data, 64'd0);
        check64({tag, "_core_data_vld"}, {63'd0, core_data_vld}, 64'd0);
        check64({tag, "_core_key"}, core_key, 64'd0);
        check64({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check64({tag, "_blk_cnt"}, {48'd0, blk_cnt}, 64'd0);
        check64({tag, "_ct_rdy"}, {63'd0, ct_rdy}, 64'd1);
`ifdef DES_CBC_DEC_TIMEOUT_EN
        check64({tag, "_err"}, {63'd0, err}, 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        logic [63:0] v;
        logic [63:0] exp_hold;

        rst = 1'b1; key = 64'd0; iv_load = 1'b0; iv = 64'd0; ct = 64'd0; ct_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // Known-answer block with zero IV, plus latency to pt_vld.
        load_iv(64'd0);
        send(KAT_CT, KAT_KEY, 1'b1);
        @(negedge clk);
        check64("launch_core_data_vld", {63'd0, core_data_vld}, 64'd1);
        check64("launch_core_data", core_data, KAT_CT);
        check64("launch_core_key", core_key, KAT_KEY);
        n = 1;
        while (!pt_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        check64("pt_vld_latency", 64'(n), 64'd19);
        check64("kat_pt_direct", pt, KAT_PT);
        drain();
        check64("blk_cnt_after_1", {48'd0, blk_cnt}, 64'd1);

        // All-ones IV.
        load_iv(64'hFFFFFFFFFFFFFFFF);
        send(KAT_CT, KAT_KEY, 1'b1);
        drain();

        // Two chained blocks: second uses the first ciphertext as chain.
        load_iv(64'd0);
        send(KAT_CT, KAT_KEY, 1'b1);
        send(KAT_CT, KAT_KEY, 1'b1);
        drain();
        check64("blk_cnt_after_2", {48'd0, blk_cnt}, 64'd2);

        // Backpressure: pt held for 10 cycles, new ciphertext refused.
        rdy_force = 1'b0;
        tick();
        exp_hold = KAT_PT ^ m_chain;
        send(KAT_CT, KAT_KEY, 1'b1);
        n = 0;
        while (!pt_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        tick();
        ct = 64'hDEADBEEFCAFEF00D;
        ct_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check64("hold_pt", pt, exp_hold);
            check64("hold_pt_vld", {63'd0, pt_vld}, 64'd1);
            check64("hold_ct_rdy", {63'd0, ct_rdy}, 64'd0);
            check64("hold_no_launch", {63'd0, core_data_vld}, 64'd0);
        end
        rdy_force = 1'b1;
        tick();
        ct_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check64("release_ct_rdy", {63'd0, ct_rdy}, 64'd1);
        check64("release_busy", {63'd0, busy}, 64'd0);
        check64("release_blk_cnt", {48'd0, blk_cnt}, 64'd3);
        tick();

        // iv_load and ct_vld together: IV wins, block not taken.
        v = {$urandom, $urandom};
        iv_load = 1'b1; iv = v; ct_vld = 1'b1; ct = {$urandom, $urandom};
        @(negedge clk);
        check64("ivload_ct_rdy", {63'd0, ct_rdy}, 64'd0);
        tick();
        iv_load = 1'b0; ct_vld = 1'b0;
        m_chain = v; m_cnt = 16'd0;
        @(negedge clk);
        check64("ivload_not_taken", {63'd0, busy}, 64'd0);
        check64("ivload_blk_cnt", {48'd0, blk_cnt}, 64'd0);
        tick();
        // Spurious core result in IDLE is ignored.
        spur_req_n++;
        @(negedge clk);
        @(negedge clk);
        check64("spur_busy", {63'd0, busy}, 64'd0);
        check64("spur_pt_vld", {63'd0, pt_vld}, 64'd0);
        tick();
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        drain();
        check64("after_spur_blk_cnt", {48'd0, blk_cnt}, 64'd1);

        // Reset during WAIT; the late core result must be dropped.
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        repeat (6) tick();
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        tick();
        rst = 1'b0;
        m_chain = 64'd0; m_cnt = 16'd0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (pt_vld || busy) seen++;
        end
        check64("late_result_dropped", 64'(seen), 64'd0);
        tick();
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        drain();

        // Randomized traffic with backpressure, IV reloads and ignored
        // mid-block IV loads.
        rdy_rand = 1'b1;
        for (int b = 0; b < 40; b++) begin
            if ($urandom_range(0, 5) == 0) begin
                drain();
                load_iv({$urandom, $urandom});
            end
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                repeat (3) tick();
                iv_load = 1'b1;
                iv = {$urandom, $urandom};
                tick();
                iv_load = 1'b0;
            end
        end
        drain();
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        tick();
        check64("random_blk_cnt", {48'd0, blk_cnt}, {48'd0, m_cnt});

`ifdef DES_CBC_DEC_TIMEOUT_EN
        // Silent core: watchdog abandons the block after TIMEOUT WAIT cycles.
        core_silent = 1'b1;
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        check64("timeout_cycles", 64'(n), 64'(TIMEOUT + 2));
        check64("timeout_err", {63'd0, err}, 64'd1);
        check64("timeout_blk_cnt", {48'd0, blk_cnt}, {48'd0, m_cnt});
        check64("timeout_pt_vld", {63'd0, pt_vld}, 64'd0);
        tick();
        core_silent = 1'b0;
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        drain();
        check64("err_sticky", {63'd0, err}, 64'd1);
        load_iv(64'd0);
        @(negedge clk);
        check64("err_cleared", {63'd0, err}, 64'd0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
